psum_accum_engine: RTL and testbench
====================================

Name: psum_accum_engine

Overview:
- Parametrised successor of the single-bank partial-sum accumulator controller.
- Accumulates NUM_KERNEL parallel kernel psum lanes into an on-chip accumulation memory by read-modify-write, tile by tile, over a configured number of channel passes.
- Adds first-pass direct write (no read), signed saturating or wrapping arithmetic, widened accumulator lanes, a start/done FSM and error flags.
- Sits between the PE-array psum outputs and the psum memory controller.

Parameters:
- BIT_WIDTH, 8, width of one incoming psum lane (signed).
- ACC_WIDTH, 16, width of one stored accumulator lane (signed), >= BIT_WIDTH.
- NUM_KERNEL, 4, number of parallel kernel lanes.
- ADDR_WIDTH, 32, memory address width.
- REG_WIDTH, 32, configuration register width.
- MEM_DELAY, 1, fixed cycles from mem_rden to mem_ovld, >= 1.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; starts a layer.
- psum_dat  in  NUM_KERNEL*BIT_WIDTH  lane k at bits [k*BIT_WIDTH +: BIT_WIDTH].
- psum_vld  in  1  psum_dat valid.
- psum_end  in  1  pulse marking the last beat of a pass (may coincide with psum_vld).
- mem_radd  out  ADDR_WIDTH  read address.
- mem_rden  out  1  read enable.
- mem_odat  in  NUM_KERNEL*ACC_WIDTH  read data.
- mem_ovld  in  1  read data valid.
- mem_wadd  out  ADDR_WIDTH  write address.
- mem_wren  out  1  write enable.
- mem_idat  out  NUM_KERNEL*ACC_WIDTH  write data.
- i_conf_outputsize  in  REG_WIDTH  tile words minus 1 (TILE = outputsize+1).
- i_conf_numpass  in  REG_WIDTH  channel passes per tile, >= 1.
- i_conf_numtile  in  REG_WIDTH  tiles per layer, >= 1.
- i_conf_mode  in  REG_WIDTH  bit0: 1 = saturate, 0 = wrap; other bits ignored.
- o_busy  out  1  FSM in RUN or DRAIN.
- o_done  out  1  sticky layer-complete flag.
- o_ovf  out  1  sticky; any lane clipped or wrapped.
- o_err  out  1  sticky protocol error.
- dbg_base_addr, dbg_pass_cnt, dbg_tile_cnt  out  REG_WIDTH  internal counters.

Behaviour:
- Reset (rst=0, async): state IDLE. All counters and addresses 0. mem_rden, mem_wren, o_busy, o_done, o_ovf and o_err are 0. mem_idat is 0.
- Config is sampled into registers on i_start and held for the layer.

FSM:
- IDLE -> RUN on i_start. i_start clears o_done, o_ovf, o_err and zeroes all counters. In IDLE, psum_vld is ignored and sets o_err.
- RUN: each psum_vld beat issues one memory operation at rd_addr, then rd_addr increments.
- On psum_end, rd_addr returns to base_addr, beat_cnt clears and pass_cnt increments.
- When pass_cnt reaches numpass-1 and psum_end arrives: base_addr += TILE, pass_cnt = 0, tile_cnt increments.
- If tile_cnt == numtile-1 at that psum_end -> DRAIN.
- DRAIN: waits until the write pipeline is empty, then -> IDLE with o_done=1.
- i_start outside IDLE is ignored and sets o_err.

Pass 0 (per tile):
- mem_rden stays 0.
- Each lane is sign-extended to ACC_WIDTH and written directly at the same pipeline timing as the read path. Writes stay in order.

Pass > 0:
- mem_rden = psum_vld, mem_radd = rd_addr, same cycle (combinational from psum_vld).
- psum data and address travel through a MEM_DELAY-deep shift register aligned to mem_ovld.
- On mem_ovld, per lane: sum = mem_odat lane + sign-extended psum lane, computed at ACC_WIDTH+1 bits and registered.
- Write occurs the next cycle: mem_wren=1, mem_wadd = the delayed address.
- Read-to-write latency is MEM_DELAY+1; pass 0 write latency is also MEM_DELAY+1 from psum_vld.

Arithmetic:
- Saturate mode clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- Wrap mode truncates.
- Either case sets o_ovf when the true sum is out of range.

Errors (set o_err):
- mem_ovld arriving with no pending read.
- Pending read whose delayed valid finds mem_ovld=0; that write is skipped.
- beat_cnt exceeding TILE within a pass.
- TILE < MEM_DELAY+2 at i_start, which is a RAW hazard; the run proceeds and the result is undefined.

Simultaneous events: psum_vld and psum_end in the same cycle means the beat belongs to the ending pass.

Mid-operation reset: aborts immediately. No further mem_wren is issued and the pipeline is flushed.

Test Plan:
- NUM_KERNEL=4, TILE=4, numpass=1, numtile=1, psum lanes {1,2,3,4} x4 beats -> no mem_rden; writes addr 0..3 with {1,2,3,4} each at MEM_DELAY+1 latency; o_done=1 after drain.
- numpass=2, TILE=4, memory model returns pass-0 data -> pass 1 reads addr 0..3 and writes {2,4,6,8}; pass_cnt wraps to 0; base_addr=4.
- Saturate mode, ACC_WIDTH=16, memory lane 32760, psum +100 -> writes 32767, o_ovf=1; wrap mode -> writes -32676, o_ovf=1.
- numtile=3, TILE=5, numpass=1 -> writes cover addr 0..14 contiguously; o_done rises only after the 15th write; dbg_tile_cnt sequence 0,1,2.
- psum_vld while IDLE, then i_start during RUN -> o_err=1, no memory traffic from either event; the next i_start in IDLE clears o_err.
- rst=0 asserted asynchronously mid-pass with reads in flight -> all outputs 0 immediately, no mem_wren afterwards, FSM in IDLE.

Source files
------------

// File: rtl/psum_accum_engine_if.sv
// Psum stream from the PE array plus the read/write ports of the psum memory.
// master = accumulation engine side, slave = PE array / memory controller side.
interface psum_accum_engine_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int NUM_KERNEL = 4,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_KERNEL*BIT_WIDTH-1:0] psum_dat;
    logic                            psum_vld;
    logic                            psum_end;
    logic [ADDR_WIDTH-1:0]           mem_radd;
    logic                            mem_rden;
    logic [NUM_KERNEL*ACC_WIDTH-1:0] mem_odat;
    logic                            mem_ovld;
    logic [ADDR_WIDTH-1:0]           mem_wadd;
    logic                            mem_wren;
    logic [NUM_KERNEL*ACC_WIDTH-1:0] mem_idat;

    modport master (
        input  psum_dat, psum_vld, psum_end, mem_odat, mem_ovld,
        output mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat
    );

    modport slave (
        output psum_dat, psum_vld, psum_end, mem_odat, mem_ovld,
        input  mem_radd, mem_rden, mem_wadd, mem_wren, mem_idat
    );
endinterface

// File: rtl/psum_accum_engine.sv
// Read-modify-write accumulation of NUM_KERNEL psum lanes into the psum memory,
// tile by tile over numpass channel passes; pass 0 writes directly without a read.
module psum_accum_engine #(
    parameter int BIT_WIDTH  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int NUM_KERNEL = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 32,
    parameter int MEM_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    psum_accum_engine_if.master   bus,
    input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
    input  logic [REG_WIDTH-1:0]  i_conf_numpass,
    input  logic [REG_WIDTH-1:0]  i_conf_numtile,
    input  logic [REG_WIDTH-1:0]  i_conf_mode,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ovf,
    output logic                  o_err,
    output logic [REG_WIDTH-1:0]  dbg_base_addr,
    output logic [REG_WIDTH-1:0]  dbg_pass_cnt,
    output logic [REG_WIDTH-1:0]  dbg_tile_cnt
);

    localparam int PW = NUM_KERNEL * BIT_WIDTH;
    localparam int AW = NUM_KERNEL * ACC_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state;

    logic [REG_WIDTH-1:0]  conf_tile, conf_numpass, conf_numtile;
    logic                  conf_sat;
    logic [ADDR_WIDTH-1:0] base_addr, rd_addr;
    logic [REG_WIDTH-1:0]  beat_cnt, pass_cnt, tile_cnt;

    // Delay line aligning each issued beat with its mem_ovld slot
    logic [MEM_DELAY-1:0]  pl_vld, pl_rd;
    logic [ADDR_WIDTH-1:0] pl_addr [MEM_DELAY];
    logic [PW-1:0]         pl_dat  [MEM_DELAY];

    logic                  wr_vld;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [AW-1:0]         wr_dat;

    logic                  issue, tap_vld, tap_rd, wr_fire, pipe_empty;
    logic [ADDR_WIDTH-1:0] tap_addr, tile_step;
    logic [PW-1:0]         tap_dat;
    logic [AW-1:0]         nxt_dat;
    logic                  nxt_ovf;

    logic signed [BIT_WIDTH-1:0] p_lane;
    logic signed [ACC_WIDTH-1:0] m_lane;
    logic signed [ACC_WIDTH:0]   p_ext, m_ext, lane_sum;
    logic [ACC_WIDTH-1:0]        lane_res;

    logic unused_mode;
    assign unused_mode = &{1'b0, i_conf_mode[REG_WIDTH-1:1]};

    assign issue      = (state == RUN) && bus.psum_vld;
    assign tap_vld    = pl_vld[MEM_DELAY-1];
    assign tap_rd     = pl_rd[MEM_DELAY-1];
    assign tap_addr   = pl_addr[MEM_DELAY-1];
    assign tap_dat    = pl_dat[MEM_DELAY-1];
    assign wr_fire    = tap_vld && (!tap_rd || bus.mem_ovld);
    assign pipe_empty = (pl_vld == '0) && !wr_vld;
    assign tile_step  = ADDR_WIDTH'(conf_tile);

    assign bus.mem_rden = issue && (pass_cnt != '0);
    assign bus.mem_radd = rd_addr;
    assign bus.mem_wren = wr_vld;
    assign bus.mem_wadd = wr_addr;
    assign bus.mem_idat = wr_dat;

    assign dbg_base_addr = REG_WIDTH'(base_addr);
    assign dbg_pass_cnt  = pass_cnt;
    assign dbg_tile_cnt  = tile_cnt;

    // Per-lane sum at ACC_WIDTH+1 bits; pass-0 beats add zero instead of memory data
    always_comb begin
        nxt_dat  = '0;
        nxt_ovf  = 1'b0;
        p_lane   = '0;
        m_lane   = '0;
        p_ext    = '0;
        m_ext    = '0;
        lane_sum = '0;
        lane_res = '0;
        for (int unsigned k = 0; k < NUM_KERNEL; k++) begin
            p_lane   = tap_dat[k*BIT_WIDTH +: BIT_WIDTH];
            m_lane   = bus.mem_odat[k*ACC_WIDTH +: ACC_WIDTH];
            p_ext    = (ACC_WIDTH+1)'(p_lane);
            m_ext    = tap_rd ? (ACC_WIDTH+1)'(m_lane) : '0;
            lane_sum = p_ext + m_ext;
            lane_res = lane_sum[ACC_WIDTH-1:0];
            if (lane_sum[ACC_WIDTH] != lane_sum[ACC_WIDTH-1]) begin
                nxt_ovf = 1'b1;
                if (conf_sat)
                    lane_res = lane_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
            nxt_dat[k*ACC_WIDTH +: ACC_WIDTH] = lane_res;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            conf_tile    <= '0;
            conf_numpass <= '0;
            conf_numtile <= '0;
            conf_sat     <= 1'b0;
            base_addr    <= '0;
            rd_addr      <= '0;
            beat_cnt     <= '0;
            pass_cnt     <= '0;
            tile_cnt     <= '0;
            pl_vld       <= '0;
            pl_rd        <= '0;
            for (int unsigned i = 0; i < MEM_DELAY; i++) begin
                pl_addr[i] <= '0;
                pl_dat[i]  <= '0;
            end
            wr_vld       <= 1'b0;
            wr_addr      <= '0;
            wr_dat       <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_ovf        <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            pl_vld[0]  <= issue;
            pl_rd[0]   <= issue && (pass_cnt != '0);
            pl_addr[0] <= rd_addr;
            pl_dat[0]  <= bus.psum_dat;
            for (int unsigned i = 1; i < MEM_DELAY; i++) begin
                pl_vld[i]  <= pl_vld[i-1];
                pl_rd[i]   <= pl_rd[i-1];
                pl_addr[i] <= pl_addr[i-1];
                pl_dat[i]  <= pl_dat[i-1];
            end

            wr_vld <= wr_fire;
            if (wr_fire) begin
                wr_addr <= tap_addr;
                wr_dat  <= nxt_dat;
                if (nxt_ovf)
                    o_ovf <= 1'b1;
            end

            // Unsolicited read data, or a pending read whose data never came (write dropped)
            if (bus.mem_ovld && !(tap_vld && tap_rd))
                o_err <= 1'b1;
            if (tap_vld && tap_rd && !bus.mem_ovld)
                o_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (bus.psum_vld)
                        o_err <= 1'b1;
                    if (i_start) begin
                        state        <= RUN;
                        o_busy       <= 1'b1;
                        conf_tile    <= i_conf_outputsize + REG_WIDTH'(1);
                        conf_numpass <= i_conf_numpass;
                        conf_numtile <= i_conf_numtile;
                        conf_sat     <= i_conf_mode[0];
                        base_addr    <= '0;
                        rd_addr      <= '0;
                        beat_cnt     <= '0;
                        pass_cnt     <= '0;
                        tile_cnt     <= '0;
                        o_done       <= 1'b0;
                        o_ovf        <= 1'b0;
                        o_err        <= (i_conf_outputsize < REG_WIDTH'(MEM_DELAY + 1));
                    end
                end
                RUN: begin
                    if (i_start)
                        o_err <= 1'b1;
                    if (bus.psum_vld) begin
                        if (beat_cnt >= conf_tile)
                            o_err <= 1'b1;
                        rd_addr  <= rd_addr + ADDR_WIDTH'(1);
                        beat_cnt <= beat_cnt + REG_WIDTH'(1);
                    end
                    if (bus.psum_end) begin
                        beat_cnt <= '0;
                        if (pass_cnt == conf_numpass - REG_WIDTH'(1)) begin
                            base_addr <= base_addr + tile_step;
                            rd_addr   <= base_addr + tile_step;
                            pass_cnt  <= '0;
                            tile_cnt  <= tile_cnt + REG_WIDTH'(1);
                            if (tile_cnt == conf_numtile - REG_WIDTH'(1))
                                state <= DRAIN;
                        end else begin
                            rd_addr  <= base_addr;
                            pass_cnt <= pass_cnt + REG_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (i_start)
                        o_err <= 1'b1;
                    if (pipe_empty) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum_engine.sv
// Directed bench for psum_accum_engine: a memory model answers reads, and a
// scoreboard queue of expected writes is filled at stimulus time and drained by a write monitor.
module tb_psum_accum_engine;

    localparam int BW = 8;
    localparam int ACC = 16;
    localparam int NK = 4;
    localparam int MD = 1;
    localparam longint MAXV = (64'sd1 <<< (ACC-1)) - 1;
    localparam longint MINV = -(64'sd1 <<< (ACC-1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic i_start = 1'b0;
    logic [31:0] conf_os = '0, conf_np = '0, conf_nt = '0, conf_mode = '0;
    logic o_busy, o_done, o_ovf, o_err;
    logic [31:0] dbg_base_addr, dbg_pass_cnt, dbg_tile_cnt;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit exp_ovf;

    psum_accum_engine_if #(.BIT_WIDTH(BW), .ACC_WIDTH(ACC), .NUM_KERNEL(NK), .ADDR_WIDTH(32)) bus_if ();

    psum_accum_engine #(
        .BIT_WIDTH(BW), .ACC_WIDTH(ACC), .NUM_KERNEL(NK),
        .ADDR_WIDTH(32), .REG_WIDTH(32), .MEM_DELAY(MD)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .bus(bus_if.master),
        .i_conf_outputsize(conf_os), .i_conf_numpass(conf_np),
        .i_conf_numtile(conf_nt), .i_conf_mode(conf_mode),
        .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf), .o_err(o_err),
        .dbg_base_addr(dbg_base_addr), .dbg_pass_cnt(dbg_pass_cnt), .dbg_tile_cnt(dbg_tile_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: fixed MD-cycle read latency, its pipeline shares the engine reset
    logic [NK*ACC-1:0] ram [64];
    logic [NK*ACC-1:0] model_mem [64];
    logic [MD-1:0]     rv_pipe;
    logic [NK*ACC-1:0] rd_pipe [MD];
    logic              poke_en = 1'b0;
    logic [5:0]        poke_addr = '0;
    logic [NK*ACC-1:0] poke_word = '0;

    always @(posedge clk) begin
        if (bus_if.mem_wren) ram[bus_if.mem_wadd[5:0]] <= bus_if.mem_idat;
        if (poke_en) ram[poke_addr] <= poke_word;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_pipe <= '0;
            for (int i = 0; i < MD; i++) rd_pipe[i] <= '0;
        end else begin
            rv_pipe[0] <= bus_if.mem_rden;
            rd_pipe[0] <= ram[bus_if.mem_radd[5:0]];
            for (int i = 1; i < MD; i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    assign bus_if.mem_ovld = rv_pipe[MD-1];
    assign bus_if.mem_odat = rd_pipe[MD-1];

    typedef struct {
        logic [31:0]       addr;
        logic [NK*ACC-1:0] data;
        int                cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.mem_wren) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 64'(bus_if.mem_wadd), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus_if.mem_wadd), 64'(e.addr));
                chk("wr_data", bus_if.mem_idat, e.data);
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    function automatic logic [31:0] pk4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [63:0] w4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Independent reference: integer sum, then clamp or reduce modulo 2^ACC
    function automatic logic [NK*ACC-1:0] model_word(input logic [NK*ACC-1:0] m,
            input logic [NK*BW-1:0] p, input bit rd, input bit sat, output bit ovf);
        logic [NK*ACC-1:0] r;
        ovf = 1'b0;
        r = '0;
        for (int k = 0; k < NK; k++) begin
            logic signed [BW-1:0]  ps;
            logic signed [ACC-1:0] ms;
            longint s;
            ps = p[k*BW +: BW];
            ms = rd ? m[k*ACC +: ACC] : '0;
            s = longint'(ps) + longint'(ms);
            if (s > MAXV || s < MINV) begin
                ovf = 1'b1;
                if (sat) s = (s > MAXV) ? MAXV : MINV;
            end
            r[k*ACC +: ACC] = ACC'(s);
        end
        return r;
    endfunction

    task automatic start(input int os, input int np, input int nt, input int mode);
        @(negedge clk);
        conf_os = os; conf_np = np; conf_nt = nt; conf_mode = mode;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic beat(input int addr, input bit rd, input logic [31:0] dat, input bit endp);
        exp_t e;
        bit ov;
        @(negedge clk);
        bus_if.psum_vld = 1'b1;
        bus_if.psum_dat = dat;
        bus_if.psum_end = endp;
        e.addr = addr;
        e.data = model_word(model_mem[addr], dat, rd, conf_mode[0], ov);
        e.cyc  = cyc + MD + 1;
        exp_ovf |= ov;
        model_mem[addr] = e.data;
        sb.push_back(e);
        #1;
        chk("mem_rden", 64'(bus_if.mem_rden), 64'(rd));
        if (rd) chk("mem_radd", 64'(bus_if.mem_radd), 64'(addr));
    endtask

    task automatic idle();
        @(negedge clk);
        bus_if.psum_vld = 1'b0;
        bus_if.psum_end = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !o_done; i++) @(negedge clk);
        chk("done_within_budget", 64'(o_done), 64'd1);
        chk("busy_after_done", 64'(o_busy), 64'd0);
        chk("writes_before_done", 64'(sb.size()), 64'd0);
        chk("ovf_after_layer", 64'(o_ovf), 64'(exp_ovf));
    endtask

    task automatic poke(input int addr, input logic [63:0] word);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = addr[5:0]; poke_word = word;
        model_mem[addr] = word;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    initial begin
        bus_if.psum_vld = 1'b0;
        bus_if.psum_end = 1'b0;
        bus_if.psum_dat = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;

        // Reset state
        #12;
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_ovf", 64'(o_ovf), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_wren", 64'(bus_if.mem_wren), 64'd0);
        chk("rst_idat", bus_if.mem_idat, 64'd0);
        chk("rst_base", 64'(dbg_base_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single pass, single tile: direct writes only
        start(3, 1, 1, 1);
        chk("busy_run", 64'(o_busy), 64'd1);
        for (int b = 0; b < 4; b++) beat(b, 1'b0, pk4(1, 2, 3, 4), b == 3);
        idle();
        wait_done(20);
        chk("t1_err", 64'(o_err), 64'd0);

        // Two passes: pass 1 reads back pass 0 and doubles it
        start(3, 2, 1, 1);
        for (int b = 0; b < 4; b++) beat(b, 1'b0, pk4(1, 2, 3, 4), b == 3);
        idle();
        chk("t2_pass_cnt_1", 64'(dbg_pass_cnt), 64'd1);
        for (int b = 0; b < 4; b++) beat(b, 1'b1, pk4(1, 2, 3, 4), b == 3);
        idle();
        chk("t2_pass_cnt_wrap", 64'(dbg_pass_cnt), 64'd0);
        chk("t2_base_addr", 64'(dbg_base_addr), 64'd4);
        wait_done(20);
        chk("t2_ram3", ram[3], w4(2, 4, 6, 8));

        // Saturate then wrap, with memory primed near both rails
        for (int mode = 1; mode >= 0; mode--) begin
            start(3, 2, 1, mode);
            for (int b = 0; b < 4; b++) beat(b, 1'b0, pk4(0, 0, 0, 0), b == 3);
            idle();
            repeat (3) @(negedge clk);
            for (int b = 0; b < 4; b++) poke(b, w4(32760, -32760, 5, 0));
            chk("arith_ovf_before", 64'(o_ovf), 64'd0);
            for (int b = 0; b < 4; b++) beat(b, 1'b1, pk4(100, -100, -3, 0), b == 3);
            idle();
            wait_done(20);
            chk("arith_ram0", ram[0], mode ? w4(32767, -32768, 2, 0) : w4(-32676, 32676, 2, 0));
        end

        // Three tiles of five words
        start(4, 1, 3, 1);
        chk("t4_done_cleared", 64'(o_done), 64'd0);
        for (int t = 0; t < 3; t++) begin
            chk("t4_tile_cnt", 64'(dbg_tile_cnt), 64'(t));
            chk("t4_base", 64'(dbg_base_addr), 64'(t * 5));
            for (int b = 0; b < 5; b++) beat(t * 5 + b, 1'b0, pk4(t * 5 + b, t + 1, -b, 7), b == 4);
            idle();
        end
        wait_done(20);
        chk("t4_ram14", ram[14], w4(14, 3, -4, 7));

        // Protocol errors: stray beat in IDLE, start while running
        chk("t5_err_clear", 64'(o_err), 64'd0);
        @(negedge clk);
        bus_if.psum_vld = 1'b1;
        #1;
        chk("t5_idle_rden", 64'(bus_if.mem_rden), 64'd0);
        idle();
        chk("t5_idle_err", 64'(o_err), 64'd1);
        start(3, 1, 1, 1);
        chk("t5_start_clears_err", 64'(o_err), 64'd0);
        @(negedge clk);
        i_start = 1'b1;
        #1;
        chk("t5_run_rden", 64'(bus_if.mem_rden), 64'd0);
        @(negedge clk);
        i_start = 1'b0;
        chk("t5_run_err", 64'(o_err), 64'd1);
        chk("t5_still_pass0", 64'(dbg_pass_cnt), 64'd0);
        for (int b = 0; b < 4; b++) beat(b, 1'b0, pk4(9, 8, 7, 6), b == 3);
        idle();
        wait_done(20);

        // Asynchronous reset with reads in flight
        start(3, 2, 1, 1);
        chk("t6_err_cleared", 64'(o_err), 64'd0);
        for (int b = 0; b < 4; b++) beat(b, 1'b0, pk4(1, 1, 1, 1), b == 3);
        beat(0, 1'b1, pk4(1, 1, 1, 1), 1'b0);
        beat(1, 1'b1, pk4(1, 1, 1, 1), 1'b0);
        #1;
        rst = 1'b0;
        bus_if.psum_vld = 1'b0;
        #1;
        sb.delete();
        chk("t6_wren", 64'(bus_if.mem_wren), 64'd0);
        chk("t6_rden", 64'(bus_if.mem_rden), 64'd0);
        chk("t6_busy", 64'(o_busy), 64'd0);
        chk("t6_idat", bus_if.mem_idat, 64'd0);
        chk("t6_pass", 64'(dbg_pass_cnt), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_idle_busy", 64'(o_busy), 64'd0);
        chk("t6_no_err", 64'(o_err), 64'd0);
        chk("t6_done", 64'(o_done), 64'd0);
        chk("final_queue_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
